// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: opcodes,
// FSM state encoding and the default iteration count.
package mult_div_pkg;

   localparam int MDU_ITERS = 32;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the remainder and subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quot,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quot_next
);

   logic [WIDTH:0] shifted;
   logic           fits;

   always_comb begin
      shifted = {rem, quot[WIDTH-1]};
      fits    = (shifted >= {1'b0, divisor});
      // The remainder stays below the divisor, so a WIDTH-bit subtract is exact.
      if (fits) begin
         rem_next  = shifted[WIDTH-1:0] - divisor;
         quot_next = {quot[WIDTH-2:0], 1'b1};
      end else begin
         rem_next  = shifted[WIDTH-1:0];
         quot_next = {quot[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer
// feeding HI/LO. Optional macro MULT_DIV_ZERO_DETECT_EN short-circuits div by zero.
module mult_div_seq
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = MDU_ITERS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = $clog2(ITERS);

   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg(v) : v;
   endfunction

   state_t                    state, state_next;
   logic [CW-1:0]             count;
   logic                      op_r;
   logic signed [WIDTH-1:0]   a_r;
   logic                      b_sign;
   logic signed [2*WIDTH+1:0] acc;
   logic signed [2*WIDTH+1:0] acc_step;
   logic signed [WIDTH:0]     mcand, upper, upper_sum;
   logic [WIDTH-1:0]          rem, quot, abs_b, rem_next, quot_next;
   logic                      b_is_zero;

   assign b_is_zero = (b == '0);

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (rem),
      .quot     (quot),
      .divisor  (abs_b),
      .rem_next (rem_next),
      .quot_next(quot_next)
   );

   // Booth step: acc = {upper(WIDTH+1), multiplier(WIDTH), q-1}; the extra
   // upper bit keeps -(-2^(WIDTH-1)) representable.
   always_comb begin
      mcand     = {a_r[WIDTH-1], a_r};
      upper     = acc[2*WIDTH+1:WIDTH+1];
      upper_sum = upper;
      case (acc[1:0])
         2'b01:   upper_sum = upper + mcand;
         2'b10:   upper_sum = upper - mcand;
         default: upper_sum = upper;
      endcase
      acc_step = $signed({upper_sum, acc[WIDTH:0]}) >>> 1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (op == OP_DIV) begin
`ifdef MULT_DIV_ZERO_DETECT_EN
                  state_next = b_is_zero ? DONE : DIV;
`else
                  state_next = DIV;
`endif
               end else begin
                  state_next = MULT;
               end
            end
         end
         MULT:    if (count == '0) state_next = FIX;
         DIV:     if (count == '0) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE:      if (start) count <= CW'(ITERS - 1);
            MULT, DIV: count <= count - 1'b1;
            FIX: begin
               if (op_r == OP_MULT) begin
                  hi <= acc[2*WIDTH:WIDTH+1];
                  lo <= acc[WIDTH:1];
               end else begin
                  hi <= a_r[WIDTH-1] ? neg(rem) : rem;
                  lo <= (a_r[WIDTH-1] ^ b_sign) ? neg(quot) : quot;
               end
            end
            default: ;
         endcase
      end
   end

   // Operand and working registers carry no reset; the FSM gates their use.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (start) begin
               op_r   <= op;
               a_r    <= a;
               b_sign <= b[WIDTH-1];
               acc    <= {{(WIDTH+1){1'b0}}, b, 1'b0};
               rem    <= '0;
               quot   <= abs_val(a);
               abs_b  <= abs_val(b);
            end
         end
         MULT: acc <= acc_step;
         DIV: begin
            rem  <= rem_next;
            quot <= quot_next;
         end
         default: ;
      endcase
   end

`ifdef MULT_DIV_ZERO_DETECT_EN
   logic dz;
   always_ff @(posedge clk) begin
      if (reset) dz <= 1'b0;
      else       dz <= (state == IDLE) && start && (op == OP_DIV) && b_is_zero;
   end
   assign div_zero = dz;
`else
   assign div_zero = 1'b0;
`endif

endmodule
